// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic echo meter: state encoding,
// 50 MHz timing defaults and result constants.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  // Timing defaults for a 50 MHz clk
  localparam int unsigned TRIG_CYCLES_DEF     = 500;        // 10 us
  localparam int unsigned RISE_TIMEOUT_DEF    = 100000;     // 2 ms
  localparam int unsigned MAX_ECHO_CYCLES_DEF = 1900000;    // 38 ms
  localparam int unsigned CYCLE_PERIOD_DEF    = 3000000;    // 60 ms

  // Result written when no valid echo was timed
  localparam logic [31:0] ECHO_NO_RESULT = 32'hFFFF_FFFF;

  // Round-trip echo cycles per centimetre at 50 MHz, used by the
  // downstream distance comparator
  localparam int unsigned CYCLES_PER_CM = 2900;

  // Saturating increment so no counter can ever wrap to zero
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous echo pin, followed by a
// history flop that turns the synchronized level into rise/fall pulses.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);

  logic echo_meta;
  logic echo_sync_q;
  logic echo_hist;

  // Synchronizer chain plus one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta   <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_hist   <= 1'b0;
    end else begin
      echo_meta   <= echo;
      echo_sync_q <= echo_meta;
      echo_hist   <= echo_sync_q;
    end
  end

  assign level = echo_sync_q;
  assign rise  = echo_sync_q & ~echo_hist;
  assign fall  = ~echo_sync_q & echo_hist;

endmodule

// File: rtl/ultrasonic_echo_meter.sv
// HC-SR04 style ranging controller: fires the trigger pulse, times the
// echo width in clk cycles and publishes one result per ranging period.
//
// state     | meaning
// ----------|--------------------------------------------------------
// IDLE      | waiting for enable; period counter held at zero
// TRIG      | trigger pin high for TRIG_CYCLES
// WAIT_RISE | waiting for a synchronized echo rising edge
// MEASURE   | counting echo high cycles until fall or width limit
// HOLDOFF   | waiting for the ranging period to elapse
module ultrasonic_echo_meter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES     = TRIG_CYCLES_DEF,
  parameter int unsigned RISE_TIMEOUT    = RISE_TIMEOUT_DEF,
  parameter int unsigned MAX_ECHO_CYCLES = MAX_ECHO_CYCLES_DEF,
  parameter int unsigned CYCLE_PERIOD    = CYCLE_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic [31:0] echo_duration,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  state_t      state;
  state_t      next_state;
  logic [31:0] period_cnt;
  logic [31:0] phase_tmr;
  logic [31:0] width_cnt;
  logic        echo_level;
  logic        echo_rise;
  logic        echo_fall;
  logic        result_load;
  logic        result_timeout;
  logic [31:0] result_value;
  logic        phase_done;
  logic        width_limit;

  echo_sync u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .echo  (echo),
    .level (echo_level),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  assign phase_done  = (phase_tmr == 32'd0);
  assign width_limit = (width_cnt >= MAX_ECHO_CYCLES);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a rise takes priority over a coincident timeout,
  // and a fall over a coincident width limit, so a real echo always wins
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable) next_state = TRIG;
      end
      TRIG: begin
        if (phase_done) next_state = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_rise)       next_state = MEASURE;
        else if (phase_done) next_state = HOLDOFF;
      end
      MEASURE: begin
        if (echo_fall || width_limit) next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (period_cnt >= CYCLE_PERIOD - 1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: which cycle produces a result and what it is
  always_comb begin
    result_load    = 1'b0;
    result_timeout = 1'b0;
    result_value   = ECHO_NO_RESULT;
    busy           = (state != IDLE);
    case (state)
      WAIT_RISE: begin
        if (!echo_rise && phase_done) begin
          result_load    = 1'b1;
          result_timeout = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          result_load  = 1'b1;
          result_value = width_cnt;
        end else if (width_limit) begin
          result_load    = 1'b1;
          result_timeout = 1'b1;
        end
      end
      default: begin
        result_load = 1'b0;
      end
    endcase
  end

  // Period counter: zero while idle, so it reads 0 on the first TRIG cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= 32'd0;
    end else if (state == IDLE) begin
      period_cnt <= 32'd0;
    end else begin
      period_cnt <= sat_inc(period_cnt);
    end
  end

  // Phase down-timer shared by the trigger pulse and the rise timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_tmr <= 32'd0;
    end else if (state == IDLE && next_state == TRIG) begin
      phase_tmr <= TRIG_CYCLES - 1;
    end else if (state == TRIG && next_state == WAIT_RISE) begin
      phase_tmr <= RISE_TIMEOUT - 1;
    end else if (!phase_done) begin
      phase_tmr <= phase_tmr - 32'd1;
    end
  end

  // Echo width counter: cleared on the rise, counts high cycles in MEASURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt <= 32'd0;
    end else if (state == WAIT_RISE && echo_rise) begin
      width_cnt <= 32'd0;
    end else if (state == MEASURE && echo_level) begin
      width_cnt <= sat_inc(width_cnt);
    end
  end

  // Registered outputs; trigger follows next_state so it is glitch-free
  // and aligned exactly with the TRIG state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger       <= 1'b0;
      valid         <= 1'b0;
      timeout       <= 1'b0;
      echo_duration <= 32'd0;
    end else begin
      trigger <= (next_state == TRIG);
      valid   <= result_load;
      timeout <= result_timeout;
      if (result_load) echo_duration <= result_value;
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_meter.sv
// Self-checking bench for ultrasonic_echo_meter with shortened timing.
module tb_ultrasonic_echo_meter;

  localparam int TRIG_CYCLES     = 10;
  localparam int RISE_TIMEOUT    = 100;
  localparam int MAX_ECHO_CYCLES = 20000;
  localparam int CYCLE_PERIOD    = 30000;
  localparam logic [31:0] NO_RES = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] dur;
    int          tol;
    logic        tmo;
    bit          chk_lat;
    int          ref_cyc;
    int          lat_min;
    int          lat_max;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        echo = 1'b0;
  logic        trigger;
  logic [31:0] echo_duration;
  logic        valid;
  logic        timeout;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   rise_count = 0;
  int   fall_count = 0;
  bit   trig_prev = 1'b0;
  bit   prev_valid = 1'b0;
  logic [31:0] prev_dur = 32'd0;
  exp_t sb[$];

  ultrasonic_echo_meter #(
    .TRIG_CYCLES     (TRIG_CYCLES),
    .RISE_TIMEOUT    (RISE_TIMEOUT),
    .MAX_ECHO_CYCLES (MAX_ECHO_CYCLES),
    .CYCLE_PERIOD    (CYCLE_PERIOD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .echo          (echo),
    .trigger       (trigger),
    .echo_duration (echo_duration),
    .valid         (valid),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] dur, input int tol, input logic tmo,
                          input bit chk_lat, input int ref_cyc, input int lat_min,
                          input int lat_max);
    exp_t e;
    e.dur = dur; e.tol = tol; e.tmo = tmo;
    e.chk_lat = chk_lat; e.ref_cyc = ref_cyc; e.lat_min = lat_min; e.lat_max = lat_max;
    sb.push_back(e);
  endtask

  // Output monitor / scoreboard, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    longint a;
    int lat;
    bit ok;
    #1;
    if (trigger === 1'b1 && !trig_prev) begin
      rise_cyc = cyc;
      rise_count++;
    end
    if (trigger === 1'b0 && trig_prev) begin
      fall_cyc = cyc;
      fall_count++;
      check("trig_len", 32'(cyc - rise_cyc), 32'(TRIG_CYCLES));
    end
    trig_prev = (trigger === 1'b1);
    if (valid === 1'b1) begin
      if (prev_valid) check("valid_twice", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        check("valid_unexp", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.tol == 0) begin
          check("dur", echo_duration, e.dur);
        end else begin
          a = longint'(echo_duration);
          ok = (a >= longint'(e.dur) - e.tol) && (a <= longint'(e.dur) + e.tol);
          check("dur_range", 32'(ok), 32'd1);
        end
        check("tmo_flag", 32'(timeout), 32'(e.tmo));
        if (e.chk_lat) begin
          lat = cyc - e.ref_cyc;
          ok = (lat >= e.lat_min) && (lat <= e.lat_max);
          check("latency", 32'(ok), 32'd1);
        end
      end
    end
    if (timeout === 1'b1) check("tmo_with_valid", 32'(valid), 32'd1);
    if (rst_n === 1'b1 && valid !== 1'b1 && echo_duration !== prev_dur)
      check("dur_hold", echo_duration, prev_dur);
    prev_valid = (valid === 1'b1);
    prev_dur   = echo_duration;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int c0, input int budget);
    for (int i = 0; i < budget && rise_count == c0; i++) @(negedge clk);
    check("trig_rise", 32'(rise_count), 32'(c0 + 1));
  endtask

  task automatic wait_fall(input int c0, input int budget);
    for (int i = 0; i < budget && fall_count == c0; i++) @(negedge clk);
    check("trig_fall", 32'(fall_count), 32'(c0 + 1));
  endtask

  task automatic wait_results(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("result_wait", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_dur", echo_duration, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    tick(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int rc;
    int fc;
    int p1_rise;
    int p2_rise;
    int target;

    // Reset held with enable=1: everything stays quiet
    tick(2);
    for (int i = 0; i < 5; i++) begin
      check("reset_trigger", 32'(trigger), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_dur", echo_duration, 32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      tick(1);
    end
    rst_n = 1'b1;

    // P1: normal 7250-cycle echo, enable dropped mid-MEASURE
    wait_rise(0, 5);
    p1_rise = rise_cyc;
    wait_fall(0, 20);
    check("busy_run", 32'(busy), 32'd1);
    tick(50);
    echo = 1'b1;
    push_exp(32'd7250, 1, 1'b0, 1'b0, 0, 0, 0);
    tick(1000);
    enable = 1'b0;
    tick(6250);
    echo = 1'b0;
    wait_results(20);
    target = p1_rise + CYCLE_PERIOD + 1 + 50;
    while (cyc < target) @(negedge clk);
    check("no_retrigger", 32'(rise_count), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // P2: echo rises but never falls -> width limit timeout
    rc = rise_count;
    fc = fall_count;
    enable = 1'b1;
    wait_rise(rc, 5);
    p2_rise = rise_cyc;
    wait_fall(fc, 20);
    tick(30);
    echo = 1'b1;
    push_exp(NO_RES, 0, 1'b1, 1'b1, cyc, MAX_ECHO_CYCLES, MAX_ECHO_CYCLES + 5);
    wait_results(MAX_ECHO_CYCLES + 50);

    // P3: echo still high from before the trigger -> rise timeout;
    // also checks the trigger-to-trigger period
    rc = rise_count;
    fc = fall_count;
    wait_rise(rc, CYCLE_PERIOD);
    check("period", 32'(rise_cyc - p2_rise), 32'(CYCLE_PERIOD + 1));
    wait_fall(fc, 20);
    push_exp(NO_RES, 0, 1'b1, 1'b1, fall_cyc, RISE_TIMEOUT - 3, RISE_TIMEOUT + 3);
    wait_results(RISE_TIMEOUT + 20);
    echo = 1'b0;
    tick(10);

    // P4: reset in HOLDOFF, then a cycle with no echo at all
    fc = fall_count;
    pulse_reset(3);
    wait_fall(fc, 30);
    push_exp(NO_RES, 0, 1'b1, 1'b1, fall_cyc, RISE_TIMEOUT - 3, RISE_TIMEOUT + 3);
    wait_results(RISE_TIMEOUT + 20);
    tick(10);

    // P5: reset pulsed mid-MEASURE; no result may appear afterwards
    fc = fall_count;
    pulse_reset(3);
    wait_fall(fc, 30);
    tick(20);
    echo = 1'b1;
    tick(500);
    rc = rise_count;
    fc = fall_count;
    echo = 1'b0;
    pulse_reset(3);
    wait_rise(rc, 5);

    // P6: fresh measurement after the mid-MEASURE reset
    wait_fall(fc, 20);
    tick(40);
    echo = 1'b1;
    push_exp(32'd1234, 1, 1'b0, 1'b0, 0, 0, 0);
    tick(1234);
    echo = 1'b0;
    wait_results(20);
    tick(20);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
